uart_rx: RTL and testbench

- Asynchronous serial receiver; the receive-side counterpart of the block's UART transmitter.
- Frame format: 8N1 (start 0, 8 data bits LSB first, stop 1).
- Samples the serial line with a configurable clocks-per-bit rate, recovers bytes and presents each one with a single-cycle valid strobe.
- Flags framing errors and, when compiled in, parity errors.

---
 rtl/uart_rx.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with 2-flop input synchronizer and mid-bit sampling.
// Latency: rx_valid is high the cycle after edge E0+2+HALF_BIT+9*CLKS_PER_BIT (E0 = sync1 capturing start edge).
// Backpressure: none; the consumer must capture rx_byte while rx_valid is high.
//
// Ports:
//   clk, reset (async, active-high)
//   rx_data       serial line, idle high, asynchronous to clk
//   rx_byte       last correctly framed byte, held until the next good frame
//   rx_valid      one-cycle strobe, rx_byte updated in the same cycle
//   rx_busy       high whenever the receiver is not idle
//   frame_error   one-cycle strobe when the stop bit samples 0
//   parity_error  one-cycle strobe on even-parity mismatch (constant 0 unless built with parity)
//
// Build option: define UART_RX_PARITY_EN to expect an even-parity bit after data bit 7.

module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_data,
   output logic [7:0] rx_byte,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       frame_error,
   output logic       parity_error
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

   state_t        state, state_nxt;
   logic          sync1, sync2, sync2_d;
   logic [CW-1:0] bit_cnt, bit_cnt_nxt;
   logic [2:0]    idx, idx_nxt;
   logic [7:0]    shift, shift_nxt;
   logic [7:0]    rx_byte_nxt;
   logic          rx_valid_nxt, frame_error_nxt;

   // Synchronizer resets to the idle level so leaving reset never looks like a start edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         sync2_d <= 1'b1;
      end else begin
         sync1   <= rx_data;
         sync2   <= sync1;
         sync2_d <= sync2;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         bit_cnt     <= '0;
         idx         <= '0;
         shift       <= '0;
         rx_byte     <= '0;
         rx_valid    <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         state       <= state_nxt;
         bit_cnt     <= bit_cnt_nxt;
         idx         <= idx_nxt;
         shift       <= shift_nxt;
         rx_byte     <= rx_byte_nxt;
         rx_valid    <= rx_valid_nxt;
         frame_error <= frame_error_nxt;
      end
   end

`ifdef UART_RX_PARITY_EN
   logic par_bad, par_bad_nxt, parity_error_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         par_bad      <= 1'b0;
         parity_error <= 1'b0;
      end else begin
         par_bad      <= par_bad_nxt;
         parity_error <= parity_error_nxt;
      end
   end
`else
   assign parity_error = 1'b0;
`endif

   assign rx_busy = (state != IDLE);

   always_comb begin
      state_nxt       = state;
      bit_cnt_nxt     = bit_cnt;
      idx_nxt         = idx;
      shift_nxt       = shift;
      rx_byte_nxt     = rx_byte;
      rx_valid_nxt    = 1'b0;
      frame_error_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_nxt      = par_bad;
      parity_error_nxt = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (sync2_d && !sync2) begin
               state_nxt   = START;
               bit_cnt_nxt = '0;
            end
         end
         START: begin
            if (bit_cnt == CNT_HALF) begin
               bit_cnt_nxt = '0;
               idx_nxt     = '0;
               // A start bit that is high again at mid-bit was a glitch.
               state_nxt   = sync2 ? IDLE : DATA;
            end else begin
               bit_cnt_nxt = bit_cnt + CW'(1);
            end
         end
         DATA: begin
            if (bit_cnt == CNT_LAST) begin
               shift_nxt[idx] = sync2;
               bit_cnt_nxt    = '0;
               idx_nxt        = idx + 3'd1;
               if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end
            end else begin
               bit_cnt_nxt = bit_cnt + CW'(1);
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (bit_cnt == CNT_LAST) begin
               // Even parity: data bits plus parity bit must XOR to 0.
               par_bad_nxt = (^shift) ^ sync2;
               bit_cnt_nxt = '0;
               state_nxt   = STOP;
            end else begin
               bit_cnt_nxt = bit_cnt + CW'(1);
            end
         end
`endif
         STOP: begin
            if (bit_cnt == CNT_LAST) begin
               bit_cnt_nxt = '0;
               if (sync2) begin
                  // Returning to IDLE mid-stop-bit lets a back-to-back start edge be caught.
                  rx_byte_nxt  = shift;
                  rx_valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                  parity_error_nxt = par_bad;
`endif
                  state_nxt = IDLE;
               end else begin
                  frame_error_nxt = 1'b1;
                  state_nxt       = BREAK;
               end
            end else begin
               bit_cnt_nxt = bit_cnt + CW'(1);
            end
         end
         BREAK: begin
            // Wait out a held-low line so it cannot start a second frame.
            if (sync2) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

   localparam int C = 16;
`ifdef UART_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int NB  = 10 + PAR;
   localparam int LAT = 154 + PAR * C;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx_data = 1'b1;
   logic [7:0] rx_byte;
   logic       rx_valid, rx_busy, frame_error, parity_error;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   int         v_cyc[$];
   logic [7:0] v_byte[$];
   logic       v_perr[$];
   int         fe_cyc[$];
   int         perr_seen = 0;

   uart_rx #(.CLKS_PER_BIT(C)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_byte(rx_byte),
      .rx_valid(rx_valid), .rx_busy(rx_busy), .frame_error(frame_error),
      .parity_error(parity_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every output strobe, sampled mid-cycle.
   always @(negedge clk) begin
      if (rx_valid) begin
         v_cyc.push_back(cyc);
         v_byte.push_back(rx_byte);
         v_perr.push_back(parity_error);
      end
      if (frame_error) fe_cyc.push_back(cyc);
      if (parity_error) perr_seen++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      v_cyc.delete();
      v_byte.delete();
      v_perr.delete();
      fe_cyc.delete();
   endtask

   // Called at a negedge; each bit is held for C clocks. e0 is the posedge where sync1 sees the start bit.
   task automatic send_frame(input logic [7:0] b, input logic stop, input logic par, output int e0);
      logic [10:0] f;
      f = {stop, par, b, 1'b0};
      if (PAR == 0) f[9] = stop;
      e0 = cyc + 1;
      for (int i = 0; i < NB; i++) begin
         rx_data = f[i];
         repeat (C) @(negedge clk);
      end
   endtask

   initial begin
      int e0, e0b;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset rx_byte", 32'(rx_byte), 32'h00);
      check("reset rx_valid", 32'(rx_valid), 32'h0);
      check("reset rx_busy", 32'(rx_busy), 32'h0);
      check("reset frame_error", 32'(frame_error), 32'h0);
      check("reset parity_error", 32'(parity_error), 32'h0);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("no false start after reset", 32'(rx_busy), 32'h0);

      // Single frame 0x55
      clear_logs();
      send_frame(8'h55, 1'b1, 1'b0, e0);
      repeat (20) @(negedge clk);
      check("0x55 pulse count", 32'(v_cyc.size()), 32'd1);
      if (v_cyc.size() == 1) begin
         check("0x55 latency", 32'(v_cyc[0] - e0), 32'(LAT));
         check("0x55 byte", 32'(v_byte[0]), 32'h55);
      end
      check("0x55 no frame_error", 32'(fe_cyc.size()), 32'd0);
      check("0x55 busy low after", 32'(rx_busy), 32'h0);
      check("0x55 byte held", 32'(rx_byte), 32'h55);

      // Back-to-back 0xA3, 0x0F
      clear_logs();
      send_frame(8'hA3, 1'b1, 1'b0, e0);
      send_frame(8'h0F, 1'b1, 1'b0, e0b);
      repeat (20) @(negedge clk);
      check("b2b pulse count", 32'(v_cyc.size()), 32'd2);
      if (v_cyc.size() == 2) begin
         check("b2b first latency", 32'(v_cyc[0] - e0), 32'(LAT));
         check("b2b spacing", 32'(v_cyc[1] - v_cyc[0]), 32'(NB * C));
         check("b2b byte0", 32'(v_byte[0]), 32'hA3);
         check("b2b byte1", 32'(v_byte[1]), 32'h0F);
      end

      // Start glitch: 4 clocks low
      clear_logs();
      rx_data = 1'b0;
      repeat (4) @(negedge clk);
      check("glitch busy in START", 32'(rx_busy), 32'h1);
      rx_data = 1'b1;
      repeat (20) @(negedge clk);
      check("glitch busy cleared", 32'(rx_busy), 32'h0);
      check("glitch no pulse", 32'(v_cyc.size()), 32'd0);
      check("glitch no frame_error", 32'(fe_cyc.size()), 32'd0);
      check("glitch byte held", 32'(rx_byte), 32'h0F);

      // Framing error: 0xFF with stop 0, line held low
      clear_logs();
      send_frame(8'hFF, 1'b0, 1'b0, e0);
      repeat (40) @(negedge clk);
      check("ferr pulse count", 32'(fe_cyc.size()), 32'd1);
      if (fe_cyc.size() == 1) check("ferr timing", 32'(fe_cyc[0] - e0), 32'(LAT));
      check("ferr no valid", 32'(v_cyc.size()), 32'd0);
      check("ferr byte held", 32'(rx_byte), 32'h0F);
      check("ferr busy during break", 32'(rx_busy), 32'h1);
      rx_data = 1'b1;
      repeat (5) @(negedge clk);
      check("ferr busy after rise", 32'(rx_busy), 32'h0);
      send_frame(8'h3C, 1'b1, 1'b0, e0);
      repeat (20) @(negedge clk);
      check("post-break pulse count", 32'(v_cyc.size()), 32'd1);
      if (v_cyc.size() == 1) check("post-break byte", 32'(v_byte[0]), 32'h3C);
      check("post-break one ferr only", 32'(fe_cyc.size()), 32'd1);

      // Reset during data bit 4 of 0x81
      clear_logs();
      rx_data = 1'b0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx_data = (i == 0);
         repeat (C) @(negedge clk);
      end
      rx_data = 1'b0;
      repeat (C / 2) @(negedge clk);
      check("pre-reset busy", 32'(rx_busy), 32'h1);
      reset = 1'b1;
      #1;
      check("mid reset rx_byte", 32'(rx_byte), 32'h00);
      check("mid reset busy", 32'(rx_busy), 32'h0);
      check("mid reset valid", 32'(rx_valid), 32'h0);
      rx_data = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (200) @(negedge clk);
      check("mid reset no pulse", 32'(v_cyc.size() + fe_cyc.size()), 32'd0);
      send_frame(8'h81, 1'b1, 1'b0, e0);
      repeat (20) @(negedge clk);
      check("after reset pulse count", 32'(v_cyc.size()), 32'd1);
      if (v_cyc.size() == 1) begin
         check("after reset latency", 32'(v_cyc[0] - e0), 32'(LAT));
         check("after reset byte", 32'(v_byte[0]), 32'h81);
      end

`ifdef UART_RX_PARITY_EN
      clear_logs();
      send_frame(8'h07, 1'b1, 1'b1, e0);
      repeat (20) @(negedge clk);
      check("par good count", 32'(v_cyc.size()), 32'd1);
      if (v_cyc.size() == 1) begin
         check("par good byte", 32'(v_byte[0]), 32'h07);
         check("par good flag", 32'(v_perr[0]), 32'h0);
      end
      clear_logs();
      send_frame(8'h07, 1'b1, 1'b0, e0);
      repeat (20) @(negedge clk);
      check("par bad count", 32'(v_cyc.size()), 32'd1);
      if (v_cyc.size() == 1) begin
         check("par bad byte", 32'(v_byte[0]), 32'h07);
         check("par bad flag", 32'(v_perr[0]), 32'h1);
      end
      check("par bad single pulse", 32'(perr_seen), 32'd1);
`else
      check("parity_error never high", 32'(perr_seen), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
